// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad geometry, key ids, FSM/frame enums and frame helpers.
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int FRAME_W  = NUM_ROWS * NUM_COLS;
    localparam logic [3:0] KEY_ZERO    = 4'd12;
    localparam logic [3:0] KEY_START   = 4'd13;
    localparam logic [3:0] KEY_CLEAR   = 4'd14;
    localparam logic [3:0] KEY_CONFIRM = 4'd15;
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_class_e;
    // x & (x-1) clears the lowest set bit, so a zero result means exactly one key
    function automatic frame_class_e classify(input logic [FRAME_W-1:0] f);
        return f == '0 ? NONE : (f & (f - 1'b1)) == '0 ? SINGLE : MULTI;
    endfunction
    // Frame bit index is {col,row}, which is exactly the key id
    function automatic logic [3:0] first_key(input logic [FRAME_W-1:0] f);
        logic [3:0] id;
        id = '0;
        for (int i = FRAME_W - 1; i >= 0; i--)
            if (f[i]) id = 4'(i);
        return id;
    endfunction
endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: row synchronizer, column dwell/rotation and 16-bit frame assembly.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [FRAME_W-1:0]  frame,
    output logic                frame_done
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    logic [NUM_ROWS-1:0] row_meta, row_sync;
    logic [DW-1:0] dwell;
    logic [1:0] col_idx;
    logic [FRAME_W-NUM_ROWS-1:0] acc;
    logic sample;
    assign sample = dwell == DWELL_LAST;
    assign col_n = ~(NUM_COLS'(1) << col_idx);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta   <= '1;
            row_sync   <= '1;
            dwell      <= '0;
            col_idx    <= '0;
            acc        <= '0;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            {row_sync, row_meta} <= {row_meta, row_n};
            dwell      <= sample ? '0 : dwell + 1'b1;
            frame_done <= sample && col_idx == 2'd3;
            if (sample) begin
                col_idx <= col_idx + 1'b1;
                // Last column goes straight into the published frame
                if (col_idx == 2'd3) frame <= {~row_sync, acc};
                else acc[col_idx*NUM_ROWS +: NUM_ROWS] <= ~row_sync;
            end
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, classifies each frame and debounces
// presses/releases into a single keydown pulse with a stable key_id.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [NUM_COLS-1:0] col_n,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic                keydown,
    output logic [3:0]          key_id,
    output logic                key_held
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [CW-1:0] DB_ONE  = CW'(1);
    localparam bit INSTANT = DEBOUNCE_SCANS == 1;
    logic [FRAME_W-1:0] frame;
    logic frame_done, accept, done;
    frame_class_e fclass;
    logic [3:0] fid, cand, cand_nx;
    logic [CW-1:0] db_cnt, db_nx;
    state_e state, state_nx;
    keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk(clk),
        .rst_n(rst_n),
        .row_n(row_n),
        .col_n(col_n),
        .frame(frame),
        .frame_done(frame_done)
    );
    assign fclass = classify(frame);
    assign fid    = first_key(frame);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cand    <= '0;
            db_cnt  <= '0;
            key_id  <= '0;
            keydown <= 1'b0;
        end else begin
            state   <= state_nx;
            cand    <= cand_nx;
            db_cnt  <= db_nx;
            keydown <= accept;
            if (accept) key_id <= cand_nx;
        end
    end
    // db_cnt is cleared on every exit, so it never climbs past DEBOUNCE_SCANS-1
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        db_nx    = db_cnt;
        accept   = 1'b0;
        done     = db_cnt >= DB_LAST;
        if (frame_done) begin
            case (state)
                IDLE: if (fclass == SINGLE) begin
                    cand_nx  = fid;
                    accept   = INSTANT;
                    state_nx = INSTANT ? HELD : PRESS_DB;
                    db_nx    = INSTANT ? '0 : DB_ONE;
                end
                PRESS_DB: if (fclass == SINGLE && fid == cand) begin
                    accept   = done;
                    state_nx = done ? HELD : PRESS_DB;
                    db_nx    = done ? '0 : db_cnt + 1'b1;
                end else if (fclass == SINGLE) begin
                    cand_nx = fid;
                    db_nx   = DB_ONE;
                end else begin
                    state_nx = IDLE;
                    db_nx    = '0;
                end
                HELD: if (fclass == NONE) begin
                    state_nx = INSTANT ? IDLE : RELEASE_DB;
                    db_nx    = INSTANT ? '0 : DB_ONE;
                end
                RELEASE_DB: if (fclass == NONE) begin
                    state_nx = done ? IDLE : RELEASE_DB;
                    db_nx    = done ? '0 : db_cnt + 1'b1;
                end else begin
                    state_nx = HELD;
                    db_nx    = '0;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
    always_comb begin
        key_held = state == HELD || state == RELEASE_DB;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-level stimulus on a modelled key matrix, checked
// against a press/release streak model of the debouncer.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] col_n, row_n, key_id;
    logic keydown, key_held;
    logic [15:0] pressed = '0;
    int checks = 0;
    int failures = 0;
    bit m_held, m_pulse;
    int m_cand, m_streak, m_rel;
    logic [3:0] m_key;
    logic [15:0] prev;

    always #5 clk = ~clk;

    // Membrane matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_n = '1;
        for (int c = 0; c < 4; c++)
            if (!col_n[c]) row_n = row_n & ~pressed[c*4 +: 4];
    end

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .col_n(col_n),
        .row_n(row_n),
        .keydown(keydown),
        .key_id(key_id),
        .key_held(key_held)
    );

    task model_reset;
        m_held = 0; m_pulse = 0; m_cand = 0; m_streak = 0; m_rel = 0;
        m_key = '0; prev = '0;
    endtask

    task model_frame(input logic [15:0] f);
        int n, id;
        n = $countones(f);
        id = 0;
        for (int i = 0; i < 16; i++) if (f[i]) id = i;
        m_pulse = 0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_streak > 0 && id == m_cand) m_streak++;
                else begin m_cand = id; m_streak = 1; end
                if (m_streak >= DB) begin
                    m_pulse = 1; m_held = 1; m_key = 4'(m_cand); m_streak = 0; m_rel = 0;
                end
            end else m_streak = 0;
        end else if (n == 0) begin
            m_rel++;
            if (m_rel >= DB) begin m_held = 0; m_rel = 0; end
        end else m_rel = 0;
    endtask

    // Applies p for one frame; the DUT's reaction to the previous frame shows up in this window
    task frame(input logic [15:0] p, input string tag);
        int pulses;
        logic [3:0] got;
        bit held_bad;
        logic seen_held;
        model_frame(prev);
        prev = p;
        pressed = p;
        pulses = 0; got = '0; held_bad = 0; seen_held = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (keydown) begin pulses++; got = key_id; end
            if (key_held !== m_held) begin held_bad = 1; seen_held = key_held; end
        end
        checks++;
        if (pulses != (m_pulse ? 1 : 0)) begin
            failures++;
            $display("FAIL %s pulses: got %0d expected %0d", tag, pulses, m_pulse ? 1 : 0);
        end
        if (m_pulse) begin
            checks++;
            if (got !== m_key) begin
                failures++;
                $display("FAIL %s pulse_id: got %0d expected %0d", tag, got, m_key);
            end
        end
        checks++;
        if (held_bad) begin
            failures++;
            $display("FAIL %s key_held: got %b expected %b", tag, seen_held, m_held);
        end
        checks++;
        if (key_id !== m_key) begin
            failures++;
            $display("FAIL %s key_id: got %0d expected %0d", tag, key_id, m_key);
        end
    endtask

    task do_reset;
        rst_n = 1'b0;
        pressed = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task check_reset_outputs(input string tag);
        checks++;
        if (col_n !== 4'b1110 || keydown !== 1'b0 || key_id !== 4'd0 || key_held !== 1'b0) begin
            failures++;
            $display("FAIL %s: got col_n=%b keydown=%b key_id=%0d key_held=%b expected 1110/0/0/0",
                     tag, col_n, keydown, key_id, key_held);
        end
    endtask

    task test_reset;
        logic [3:0] exp;
        rst_n = 1'b0;
        foreach (exp[k]) begin
            pressed = 16'h1 << ($urandom_range(0, 15));
            @(negedge clk);
            check_reset_outputs("reset_hold");
        end
        pressed = '0;
        rst_n = 1'b1;
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            exp = ~(4'b0001 << ((i / SCAN_DIV) % 4));
            checks++;
            if (col_n !== exp) begin
                failures++;
                $display("FAIL col_seq[%0d]: got %b expected %b", i, col_n, exp);
            end
        end
    endtask

    task test_clean_press;
        do_reset();
        repeat (3) frame(16'h1 << 13, "clean_press");
        repeat (5) frame(16'h0, "clean_release");
    endtask

    task test_bounce;
        frame(16'h1 << 5, "bounce_a");
        frame(16'h0, "bounce_gap");
        repeat (3) frame(16'h1 << 5, "bounce_hold");
        repeat (4) frame(16'h0, "bounce_release");
    endtask

    task test_multi;
        repeat (3) frame(16'h0011, "multi_idle");
        frame(16'h0, "multi_gap");
        repeat (3) frame(16'h1 << 8, "multi_first");
        repeat (2) frame(16'h0300, "multi_add");
        repeat (4) frame(16'h0, "multi_release");
    endtask

    task test_release_glitch;
        repeat (3) frame(16'h1 << 12, "glitch_press");
        repeat (2) frame(16'h0, "glitch_gap");
        repeat (3) frame(16'h1 << 12, "glitch_repress");
        repeat (4) frame(16'h0, "glitch_release");
    endtask

    task test_random;
        int kind, k, k2;
        k = $urandom_range(0, 15);
        repeat (30) begin
            kind = $urandom_range(0, 6);
            if (kind == 0) frame(16'h0, "rand_none");
            else if (kind <= 3) frame(16'h1 << k, "rand_same");
            else if (kind == 4) begin
                k = $urandom_range(0, 15);
                frame(16'h1 << k, "rand_new");
            end else begin
                k2 = (k + $urandom_range(1, 15)) % 16;
                frame((16'h1 << k) | (16'h1 << k2), "rand_multi");
            end
        end
        repeat (4) frame(16'h0, "rand_flush");
    endtask

    task test_reset_mid;
        int pulses;
        repeat (3) frame(16'h1 << 14, "mid_prior");
        repeat (4) frame(16'h0, "mid_prior_rel");
        repeat (2) frame(16'h1 << 15, "mid_qualify");
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (keydown) pulses++;
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        repeat (3) begin
            @(negedge clk);
            if (keydown) pulses++;
        end
        pressed = '0;
        rst_n = 1'b1;
        model_reset();
        repeat (2) frame(16'h0, "mid_after");
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_mid_pulses: got %0d expected 0", pulses);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi();
        test_release_glitch();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
